instr_fetch_cache: RTL and testbench
====================================

# instr_fetch_cache

Direct-mapped instruction cache that answers the pipeline's instruction-fetch requests and refills missing lines from a slower backing instruction memory over a request/acknowledge handshake. It replaces the zero-latency instruction memory at the IF stage: the IF stage presents the current PC, and the cache returns the instruction on a hit or asserts `stall` on a miss. The hazard logic ORs `stall` into its PC/IF-write hold.

## Interface
- `LINES`, 16: number of cache lines; power of two, ≥2.
- `WORDS`, 4: 32-bit words per line; power of two, ≥2.
- `CLK` in 1: clock; all state updates on the falling edge, matching the pipeline registers.
- `Reset_L` in 1: asynchronous, active-low reset.
- `fetchReq` in 1: IF stage requests an instruction this cycle.
- `fetchAddr` in 32: byte address (PC); bits [1:0] ignored.
- `instrOut` out 32: instruction; valid when `instrValid`=1, else 32'h00000000.
- `instrValid` out 1: combinational hit indication.
- `stall` out 1: combinational; `fetchReq & ~instrValid`.
- `flush` in 1: invalidate every line (self-modifying code / reload).
- `memReq` out 1: backing-memory read request (registered).
- `memAddr` out 32: word-aligned read address (registered).
- `memRdata` in 32: read data, sampled when `memAck`=1.
- `memAck` in 1: read completion; ignored when `memReq`=0.
- `hitCount` out 32: number of hit cycles.
- `missCount` out 32: number of refills started.

## Operation
- Address split: offset = log2(WORDS)+2 bits (word select = bits [log2(WORDS)+1:2]), index = next log2(LINES) bits, tag = remaining upper bits.
- Storage per line: valid bit, tag, WORDS data words.
- Hit = `fetchReq` & state IDLE & valid[index] & tag match. `instrOut` = data[index][word]. No hits are reported in REFILL.
- FSM states: IDLE, REFILL.
  - IDLE, `fetchReq` & miss & ~`flush`: latch line base (fetchAddr with offset bits zeroed), index and tag; word counter ← 0; `memReq` ← 1; `memAddr` ← base; `missCount` += 1; go to REFILL.
  - REFILL, `memAck`=1: data[index][counter] ← `memRdata`. If counter ≠ WORDS−1: counter += 1, `memAddr` += 4, and `memReq` stays 1. If counter = WORDS−1: valid ← 1, tag written, `memReq` ← 0, go to IDLE.
  - REFILL, `memAck`=0: hold.
- `fetchAddr` changes during REFILL are ignored. The refill completes to the latched line, and the new address is evaluated in IDLE.
- `flush`=1, any state: all valid bits ← 0 at that edge. In REFILL, the refill is aborted: `memReq` ← 0, state ← IDLE, and any `memAck` on that edge is discarded. Flush has priority over hit, miss and ack. The backing memory must tolerate request withdrawal.
- Valid bits are set only on the final word of a refill, so a partially filled line never hits.
- `hitCount` increments on each edge where hit=1. Both counters wrap modulo 2^32.

## Timing
- Reset (asynchronous, immediate): state IDLE, all valid bits 0, counter 0, `memReq` 0, `memAddr` 0, `hitCount` 0, `missCount` 0. Outputs with `fetchReq`=0: `instrOut` 0, `instrValid` 0, `stall` 0. Reset mid-refill aborts it, and the line remains invalid.
- Hit latency: 0 cycles (combinational, same cycle as the request).
- Miss penalty: 1 cycle to issue the first request, plus the sum of the per-word ack latencies. The hit is reported in the first IDLE cycle after the final ack. With single-cycle acks, `stall` is high for WORDS+1 cycles.
- `memReq` and `memAddr` change only on falling edges. The memory may assert `memAck` in the same cycle `memReq` rises.
- Data RAM and tag array: one write port, combinational read.

## Test plan
- Cold miss: after reset, fetch 0x00000040 with WORDS=4 and memory returning 0xA0+addr after a 2-cycle ack delay. Expect `memAddr` sequence 0x40, 0x44, 0x48, 0x4C; `stall` held through the final ack; then `instrValid`=1, `instrOut`=0xE0, `missCount`=1.
- Hits in line: fetch 0x44, 0x48, 0x4C on consecutive cycles. Expect `instrValid`=1 every cycle, data 0xE4/0xE8/0xEC, `hitCount`=3, no `memReq`.
- Conflict: with LINES=16, fetch 0x00000440 (same index, different tag). Expect a refill from 0x440; a later fetch of 0x40 misses again, giving `missCount`=3.
- Flush: assert `flush` for one cycle, then fetch 0x440. Expect a miss and a new refill. Assert `flush` during the second word of a refill: expect `memReq`=0 at the next edge, the line invalid, and the next fetch restarting at the line base.
- Address change mid-refill: start a refill of 0x80, switch `fetchAddr` to 0x100 during REFILL. Expect the 0x80 line to be filled completely, then a miss and refill of 0x100. A subsequent fetch of 0x80 hits.
- Reset mid-refill: drop `Reset_L` after the first ack. Expect `memReq`=0 and counters 0 immediately; a refetch of the same address is a miss.

Source files
------------

// File: rtl/instr_fetch_cache_if.sv
// Bus bundle between the IF stage / backing instruction memory and the cache.
// The cache takes the slave side; the pipeline and memory model take the master side.
interface instr_fetch_cache_if;
    // fetch side
    logic        fetchReq;
    logic [31:0] fetchAddr;
    logic [31:0] instrOut;
    logic        instrValid;
    logic        stall;
    logic        flush;
    // backing-memory side
    logic        memReq;
    logic [31:0] memAddr;
    logic [31:0] memRdata;
    logic        memAck;
    // statistics
    logic [31:0] hitCount;
    logic [31:0] missCount;

    modport slave (
        input  fetchReq, fetchAddr, flush, memRdata, memAck,
        output instrOut, instrValid, stall, memReq, memAddr, hitCount, missCount
    );

    modport master (
        output fetchReq, fetchAddr, flush, memRdata, memAck,
        input  instrOut, instrValid, stall, memReq, memAddr, hitCount, missCount
    );
endinterface

// File: rtl/instr_fetch_cache.sv
// Direct-mapped instruction cache for the IF stage. Hits are combinational;
// misses stall the pipeline while a whole line is refilled word by word from
// the backing memory. All state moves on the falling edge of CLK.
module instr_fetch_cache #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input logic                 CLK,
    input logic                 Reset_L,
    instr_fetch_cache_if.slave  bus
);
    localparam int WORD_W = $clog2(WORDS);
    localparam int IDX_W  = $clog2(LINES);
    localparam int OFF_W  = WORD_W + 2;
    localparam int TAG_W  = 32 - OFF_W - IDX_W;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t              state, state_nxt;
    logic [LINES-1:0]    valid;
    logic [TAG_W-1:0]    tags [LINES];
    logic [31:0]         data [LINES][WORDS];
    logic [IDX_W-1:0]    fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic [WORD_W-1:0]   word_cnt;

    logic [WORD_W-1:0]   req_word;
    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic                hit;
    logic                last_word;
    logic                start_fill;
    logic                take_word;
    logic                unused_addr_bits;

    // Byte-offset bits never select anything in a word-addressed cache.
    assign unused_addr_bits = &{1'b0, bus.fetchAddr[1:0]};

    assign req_word  = bus.fetchAddr[OFF_W-1:2];
    assign req_idx   = bus.fetchAddr[OFF_W+IDX_W-1:OFF_W];
    assign req_tag   = bus.fetchAddr[31:OFF_W+IDX_W];
    assign last_word = (word_cnt == WORD_W'(WORDS - 1));

    // Lookups only count while idle so a half-written line is never reported.
    assign hit            = bus.fetchReq && (state == IDLE) && valid[req_idx] &&
                            (tags[req_idx] == req_tag);
    assign bus.instrValid = hit;
    assign bus.instrOut   = hit ? data[req_idx][req_word] : 32'h0000_0000;
    assign bus.stall      = bus.fetchReq && !hit;

    // Next-state decode: start a refill on an idle miss, consume acks while refilling.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt  = state;
        start_fill = 1'b0;
        take_word  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.fetchReq && !hit) begin
                    start_fill = 1'b1;
                    state_nxt  = REFILL;
                end
            end
            REFILL: begin
                if (bus.memAck) begin
                    take_word = 1'b1;
                    if (last_word) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Flush wins over everything: it aborts a refill and discards any ack.
        if (bus.flush) begin
            state_nxt  = IDLE;
            start_fill = 1'b0;
            take_word  = 1'b0;
        end
    end

    // Control state, valid bits, memory request and statistics counters.
    always_ff @(negedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state         <= IDLE;
            valid         <= '0;
            fill_idx      <= '0;
            fill_tag      <= '0;
            word_cnt      <= '0;
            bus.memReq    <= 1'b0;
            bus.memAddr   <= 32'h0000_0000;
            bus.hitCount  <= 32'h0000_0000;
            bus.missCount <= 32'h0000_0000;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state <= state_nxt;
            if (hit) bus.hitCount <= bus.hitCount + 32'd1;
            if (bus.flush) begin
                valid      <= '0;
                bus.memReq <= 1'b0;
            end else if (start_fill) begin
                fill_idx      <= req_idx;
                fill_tag      <= req_tag;
                word_cnt      <= '0;
                bus.memReq    <= 1'b1;
                bus.memAddr   <= {bus.fetchAddr[31:OFF_W], OFF_W'(0)};
                bus.missCount <= bus.missCount + 32'd1;
            end else if (take_word) begin
                if (last_word) begin
                    valid[fill_idx] <= 1'b1;
                    bus.memReq      <= 1'b0;
                end else begin
                    word_cnt    <= word_cnt + WORD_W'(1);
                    bus.memAddr <= bus.memAddr + 32'd4;
                end
            end
        end
    end

    // Single write port into the data and tag arrays during refill.
    always_ff @(negedge CLK) begin
        // NOTE: the arrays are not reset; the valid bits alone decide whether
        // their contents can ever be observed.
        if (take_word) begin
            data[fill_idx][word_cnt] <= bus.memRdata;
            if (last_word) tags[fill_idx] <= fill_tag;
        end
    end
endmodule

// File: tb/tb_instr_fetch_cache.sv
// Directed bench for instr_fetch_cache: cold miss, in-line hits, conflict,
// flush (idle and mid-refill), address change mid-refill, reset mid-refill.
module tb_instr_fetch_cache;
    logic CLK = 1'b0;
    logic Reset_L = 1'b0;

    instr_fetch_cache_if bus ();

    instr_fetch_cache #(.LINES(16), .WORDS(4)) dut (
        .CLK     (CLK),
        .Reset_L (Reset_L),
        .bus     (bus)
    );

    // Falling edge is the active edge; inputs change on rising edges.
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int ack_delay = 0;
    int wait_cnt  = 0;
    logic [31:0] addr_log [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Backing memory: acks after ack_delay idle cycles, data = 0xA0 + address.
    initial begin
        bus.memAck   = 1'b0;
        bus.memRdata = 32'h0;
        forever begin
            @(posedge CLK);
            if (bus.memReq) begin
                if (wait_cnt >= ack_delay) begin
                    bus.memAck   = 1'b1;
                    bus.memRdata = 32'h0000_00A0 + bus.memAddr;
                    addr_log.push_back(bus.memAddr);
                    wait_cnt = 0;
                end else begin
                    bus.memAck = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bus.memAck = 1'b0;
                wait_cnt   = 0;
            end
        end
    end

    // Request addr until it hits (or the budget expires); returns stall cycles and data.
    task automatic fetch_wait(input logic [31:0] addr, input int budget,
                              output int cyc, output logic [31:0] data);
        logic held;
        held = 1'b1;
        cyc  = 0;
        @(posedge CLK);
        bus.fetchReq  = 1'b1;
        bus.fetchAddr = addr;
        #1;
        while (!bus.instrValid && cyc < budget) begin
            if (!bus.stall) held = 1'b0;
            cyc++;
            @(posedge CLK);
            #1;
        end
        check("fetch_valid", {31'b0, bus.instrValid}, 32'd1);
        check("stall_held", {31'b0, held}, 32'd1);
        data = bus.instrOut;
        bus.fetchReq = 1'b0;
    endtask

    // Single-cycle fetch expected to hit.
    task automatic fetch_hit(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        @(posedge CLK);
        bus.fetchReq  = 1'b1;
        bus.fetchAddr = addr;
        #1;
        check({tag, "_valid"}, {31'b0, bus.instrValid}, 32'd1);
        check({tag, "_data"}, bus.instrOut, exp);
        check({tag, "_nomemreq"}, {31'b0, bus.memReq}, 32'd0);
    endtask

    initial begin
        int cyc;
        logic [31:0] d;
        bus.fetchReq  = 1'b0;
        bus.fetchAddr = 32'h0;
        bus.flush     = 1'b0;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst_memreq", {31'b0, bus.memReq}, 32'd0);
        check("rst_memaddr", bus.memAddr, 32'h0);
        check("rst_hits", bus.hitCount, 32'd0);
        check("rst_misses", bus.missCount, 32'd0);
        check("rst_instr", bus.instrOut, 32'h0);
        check("rst_valid", {31'b0, bus.instrValid}, 32'd0);
        check("rst_stall", {31'b0, bus.stall}, 32'd0);
        @(posedge CLK);
        Reset_L = 1'b1;

        // Cold miss with 2-cycle ack delay
        ack_delay = 2;
        addr_log.delete();
        fetch_wait(32'h40, 60, cyc, d);
        check("cold_data", d, 32'hE0);
        check("cold_misses", bus.missCount, 32'd1);
        check("cold_nwords", addr_log.size(), 32'd4);
        if (addr_log.size() == 4) begin
            check("cold_addr0", addr_log[0], 32'h40);
            check("cold_addr1", addr_log[1], 32'h44);
            check("cold_addr2", addr_log[2], 32'h48);
            check("cold_addr3", addr_log[3], 32'h4C);
        end

        // Hits within the line
        fetch_hit("hit44", 32'h44, 32'hE4);
        fetch_hit("hit48", 32'h48, 32'hE8);
        fetch_hit("hit4c", 32'h4C, 32'hEC);
        @(posedge CLK);
        bus.fetchReq = 1'b0;
        #1;
        check("hit_count", bus.hitCount, 32'd3);

        // Conflict: same index, different tag
        ack_delay = 0;
        addr_log.delete();
        fetch_wait(32'h440, 20, cyc, d);
        check("conf_data", d, 32'h4E0);
        check("conf_addr0", (addr_log.size() > 0) ? addr_log[0] : 32'hFFFF_FFFF, 32'h440);
        fetch_wait(32'h40, 20, cyc, d);
        check("conf_remiss", cyc, 32'd5);
        check("conf_misses", bus.missCount, 32'd3);

        // Flush while idle: resident line must miss again, stall WORDS+1 cycles
        @(posedge CLK);
        bus.flush = 1'b1;
        @(posedge CLK);
        bus.flush = 1'b0;
        fetch_wait(32'h40, 20, cyc, d);
        check("flush_stall_cycles", cyc, 32'd5);
        check("flush_data", d, 32'hE0);
        check("flush_misses", bus.missCount, 32'd4);

        // Flush during the second word of a refill
        addr_log.delete();
        @(posedge CLK);
        bus.fetchReq  = 1'b1;
        bus.fetchAddr = 32'h200;
        @(posedge CLK);
        @(posedge CLK);
        bus.flush = 1'b1;
        @(posedge CLK);
        bus.flush = 1'b0;
        #1;
        check("fmid_memreq", {31'b0, bus.memReq}, 32'd0);
        check("fmid_invalid", {31'b0, bus.instrValid}, 32'd0);
        check("fmid_stall", {31'b0, bus.stall}, 32'd1);
        bus.fetchReq = 1'b0;
        addr_log.delete();
        fetch_wait(32'h200, 20, cyc, d);
        check("fmid_restart", (addr_log.size() > 0) ? addr_log[0] : 32'hFFFF_FFFF, 32'h200);
        check("fmid_data", d, 32'h2A0);
        check("fmid_misses", bus.missCount, 32'd6);

        // Address change mid-refill: 0x80 line completes, then 0x100 refills
        addr_log.delete();
        @(posedge CLK);
        bus.fetchReq  = 1'b1;
        bus.fetchAddr = 32'h80;
        @(posedge CLK);
        fetch_wait(32'h100, 30, cyc, d);
        check("chg_nwords", addr_log.size(), 32'd8);
        if (addr_log.size() == 8) begin
            check("chg_addr0", addr_log[0], 32'h80);
            check("chg_addr3", addr_log[3], 32'h8C);
            check("chg_addr4", addr_log[4], 32'h100);
        end
        check("chg_data", d, 32'h1A0);
        check("chg_misses", bus.missCount, 32'd8);
        fetch_hit("chg_hit80", 32'h80, 32'h120);
        @(posedge CLK);
        bus.fetchReq = 1'b0;

        // Reset after the first ack of a refill
        @(posedge CLK);
        bus.fetchReq  = 1'b1;
        bus.fetchAddr = 32'h300;
        @(posedge CLK);
        @(negedge CLK);
        #1;
        bus.fetchReq = 1'b0;
        Reset_L = 1'b0;
        #1;
        check("rmid_memreq", {31'b0, bus.memReq}, 32'd0);
        check("rmid_hits", bus.hitCount, 32'd0);
        check("rmid_misses", bus.missCount, 32'd0);
        @(posedge CLK);
        Reset_L = 1'b1;
        fetch_wait(32'h300, 20, cyc, d);
        check("rmid_refetch_miss", cyc, 32'd5);
        check("rmid_data", d, 32'h3A0);
        check("rmid_misses_after", bus.missCount, 32'd1);

        repeat (2) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
